// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port round-robin SPRAM arbiter with bank-turnaround protection
module sram_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int BHI = ADDR_W - 1;
   localparam int BLO = ADDR_W - 2;

   // last_q: 0 = port A granted most recently, 1 = port B
   logic              last_q, last_d;
   logic              mem_wen_q, mem_wen_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   // stage 1: read currently on mem_*; stage 2: its data is on mem_rdata
   logic              rd1_vld_q, rd1_vld_d;
   logic              rd1_port_q, rd1_port_d;
   logic              rd2_vld_q, rd2_port_q;
   logic              a_rvalid_q, b_rvalid_q;
   logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
   logic              a_elig, b_elig;
   logic              gnt_a, gnt_b;

   // Grant selection: a read on mem_* pins the bank for one more cycle so the
   // SPRAM output mux still points at it when its data comes back
   always_comb begin
      a_elig = a_req && (!rd1_vld_q || (a_addr[BHI:BLO] == mem_addr_q[BHI:BLO]));
      b_elig = b_req && (!rd1_vld_q || (b_addr[BHI:BLO] == mem_addr_q[BHI:BLO]));
      gnt_a  = 1'b0;
      gnt_b  = 1'b0;
      if (resetn) begin
         if (a_elig && b_elig) begin
            gnt_a = last_q;
            gnt_b = !last_q;
         end else begin
            gnt_a = a_elig;
            gnt_b = b_elig;
         end
      end
   end

   // Next issue-stage contents taken from the winner; address/data hold when idle
   always_comb begin
      last_d      = last_q;
      mem_wen_d   = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rd1_vld_d   = 1'b0;
      rd1_port_d  = rd1_port_q;
      if (gnt_a) begin
         last_d      = 1'b0;
         mem_wen_d   = a_we;
         mem_addr_d  = a_addr;
         mem_wdata_d = a_wdata;
         rd1_vld_d   = !a_we;
         rd1_port_d  = 1'b0;
      end else if (gnt_b) begin
         last_d      = 1'b1;
         mem_wen_d   = b_we;
         mem_addr_d  = b_addr;
         mem_wdata_d = b_wdata;
         rd1_vld_d   = !b_we;
         rd1_port_d  = 1'b1;
      end
   end

   // Issue register, round-robin pointer and first read-tracking stage
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last_q      <= 1'b1;
         mem_wen_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rd1_vld_q   <= 1'b0;
         rd1_port_q  <= 1'b0;
      end else begin
         last_q      <= last_d;
         mem_wen_q   <= mem_wen_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rd1_vld_q   <= rd1_vld_d;
         rd1_port_q  <= rd1_port_d;
      end
   end

   // Second tracking stage and read-data return to the owning port
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd2_vld_q  <= 1'b0;
         rd2_port_q <= 1'b0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
      end else begin
         rd2_vld_q  <= rd1_vld_q;
         rd2_port_q <= rd1_port_q;
         a_rvalid_q <= rd2_vld_q && !rd2_port_q;
         b_rvalid_q <= rd2_vld_q && rd2_port_q;
         if (rd2_vld_q && !rd2_port_q) begin
            a_rdata_q <= mem_rdata;
         end
         if (rd2_vld_q && rd2_port_q) begin
            b_rdata_q <= mem_rdata;
         end
      end
   end

   assign a_gnt     = gnt_a;
   assign b_gnt     = gnt_b;
   assign a_rvalid  = a_rvalid_q;
   assign b_rvalid  = b_rvalid_q;
   assign a_rdata   = a_rdata_q;
   assign b_rdata   = b_rdata_q;
   assign mem_wen   = mem_wen_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter with a banked SPRAM model
module tb_sram_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        a_req, a_we, b_req, b_we;
   logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
   logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic [15:0] a_rdata, b_rdata;
   logic        mem_wen;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;

   int vectors     = 0;
   int miscompares = 0;

   // SPRAM bank model: each bank latches its own output, the mux follows the live address
   logic [15:0] mem     [0:65535];
   logic [15:0] bank_q  [0:3];
   logic [15:0] shadow  [int];

   always #5 clk = ~clk;

   sram_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
      .clk(clk), .resetn(resetn),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always @(posedge clk) begin
      if (mem_wen) mem[mem_addr] <= mem_wdata;
      else         bank_q[mem_addr[15:14]] <= mem[mem_addr];
   end
   assign mem_rdata = bank_q[mem_addr[15:14]];

   function automatic logic [15:0] init_val(input logic [15:0] addr);
      return {addr[7:0] ^ 8'h3C, addr[15:8] ^ 8'hA5};
   endfunction

   function automatic logic [15:0] exp_data(input logic [15:0] addr);
      if (shadow.exists(int'(addr))) return shadow[int'(addr)];
      return init_val(addr);
   endfunction

   task automatic idle();
      a_req = 1'b0; a_we = 1'b0; b_req = 1'b0; b_we = 1'b0;
   endtask

   task automatic set_a(input logic we, input logic [15:0] addr, input logic [15:0] wd);
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
   endtask

   task automatic set_b(input logic we, input logic [15:0] addr, input logic [15:0] wd);
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      idle();
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      resetn = 1'b1;
      a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0;
      a_addr = 16'h0000; b_addr = 16'h0001; a_wdata = 16'h0; b_wdata = 16'h0;
      #2 resetn = 1'b0;
      @(negedge clk); #1;
      vectors++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin miscompares++; $display("FAIL rst_gnt got=%b%b exp=00", a_gnt, b_gnt); end
      vectors++; if (mem_wen !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin miscompares++; $display("FAIL rst_mem got wen=%b addr=%h wd=%h exp 0/0/0", mem_wen, mem_addr, mem_wdata); end
      vectors++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || a_rdata !== 16'h0 || b_rdata !== 16'h0) begin miscompares++; $display("FAIL rst_rd got rv=%b%b a=%h b=%h exp 0", a_rvalid, b_rvalid, a_rdata, b_rdata); end
      @(negedge clk);
      resetn = 1'b1;
      #1;
      vectors++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin miscompares++; $display("FAIL rst_first_tie got=%b%b exp=10", a_gnt, b_gnt); end
      @(negedge clk); idle();
      repeat (4) @(negedge clk);
   endtask

   task automatic test_write_read();
      apply_reset();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         idle();
         if (c == 0) set_a(1'b1, 16'h0005, 16'h1234);
         if (c == 1) set_a(1'b0, 16'h0005, 16'h0000);
         #1;
         if (c < 2) begin
            vectors++; if (a_gnt !== 1'b1) begin miscompares++; $display("FAIL wr_rd_gnt c%0d got=%b exp=1", c, a_gnt); end
         end
         vectors++; if (mem_wen !== (c == 1)) begin miscompares++; $display("FAIL wr_rd_wen c%0d got=%b exp=%b", c, mem_wen, c == 1); end
         if (c == 1) begin
            vectors++; if (mem_addr !== 16'h0005 || mem_wdata !== 16'h1234) begin miscompares++; $display("FAIL wr_rd_issue got=%h/%h exp=0005/1234", mem_addr, mem_wdata); end
         end
         if (c >= 2) begin
            vectors++; if (a_rvalid !== (c == 4)) begin miscompares++; $display("FAIL wr_rd_rvalid c%0d got=%b exp=%b", c, a_rvalid, c == 4); end
         end
         if (c == 4) begin
            vectors++; if (a_rdata !== 16'h1234) begin miscompares++; $display("FAIL wr_rd_data got=%h exp=1234", a_rdata); end
         end
      end
      shadow[5] = 16'h1234;
   endtask

   task automatic test_conflict();
      logic ea, eb;
      apply_reset();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         idle();
         if (c < 6) begin
            set_a(1'b0, 16'h0100 + 16'((c + 1) / 2), 16'h0);
            set_b(1'b0, 16'h0200 + 16'(c / 2), 16'h0);
         end
         #1;
         if (c < 6) begin
            vectors++; if (a_gnt !== (c % 2 == 0) || b_gnt !== (c % 2 == 1)) begin miscompares++; $display("FAIL conflict_gnt c%0d got=%b%b exp=%b%b", c, a_gnt, b_gnt, c % 2 == 0, c % 2 == 1); end
         end
         ea = (c >= 3 && c <= 7 && c % 2 == 1);
         eb = (c >= 4 && c <= 8 && c % 2 == 0);
         vectors++; if (a_rvalid !== ea || b_rvalid !== eb) begin miscompares++; $display("FAIL conflict_rvalid c%0d got=%b%b exp=%b%b", c, a_rvalid, b_rvalid, ea, eb); end
         if (ea) begin
            vectors++; if (a_rdata !== exp_data(16'h0100 + 16'((c - 3) / 2))) begin miscompares++; $display("FAIL conflict_adata c%0d got=%h exp=%h", c, a_rdata, exp_data(16'h0100 + 16'((c - 3) / 2))); end
         end
         if (eb) begin
            vectors++; if (b_rdata !== exp_data(16'h0200 + 16'((c - 4) / 2))) begin miscompares++; $display("FAIL conflict_bdata c%0d got=%h exp=%h", c, b_rdata, exp_data(16'h0200 + 16'((c - 4) / 2))); end
         end
      end
   endtask

   task automatic test_bank_hazard(input logic [15:0] baddr, input logic blocked);
      int bg;
      apply_reset();
      bg = blocked ? 2 : 1;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         idle();
         if (c == 0) set_a(1'b0, 16'h0010, 16'h0);
         if (c >= 1 && c <= bg) set_b(1'b0, baddr, 16'h0);
         #1;
         if (c == 0) begin
            vectors++; if (a_gnt !== 1'b1) begin miscompares++; $display("FAIL hazard_agnt got=%b exp=1", a_gnt); end
         end
         if (c >= 1 && c <= bg) begin
            vectors++; if (b_gnt !== (c == bg)) begin miscompares++; $display("FAIL hazard_bgnt %h c%0d got=%b exp=%b", baddr, c, b_gnt, c == bg); end
         end
         if (c == 2) begin
            vectors++; if (mem_addr[15:14] !== 2'b00) begin miscompares++; $display("FAIL hazard_bank c2 got=%b exp=00", mem_addr[15:14]); end
         end
         if (c == 3) begin
            vectors++; if (a_rvalid !== 1'b1 || a_rdata !== exp_data(16'h0010)) begin miscompares++; $display("FAIL hazard_adata got=%b/%h exp=1/%h", a_rvalid, a_rdata, exp_data(16'h0010)); end
         end
         if (c >= 2) begin
            vectors++; if (b_rvalid !== (c == bg + 3)) begin miscompares++; $display("FAIL hazard_brvalid %h c%0d got=%b exp=%b", baddr, c, b_rvalid, c == bg + 3); end
         end
         if (c == bg + 3) begin
            vectors++; if (b_rdata !== exp_data(baddr)) begin miscompares++; $display("FAIL hazard_bdata %h got=%h exp=%h", baddr, b_rdata, exp_data(baddr)); end
         end
      end
   endtask

   task automatic test_work_conserving();
      logic [1:0] eg;
      apply_reset();
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         idle();
         if (c == 0) set_b(1'b0, 16'h0020, 16'h0);
         if (c == 1) begin set_a(1'b0, 16'h8000, 16'h0); set_b(1'b1, 16'h0021, 16'hBEEF); end
         if (c == 2) begin set_a(1'b0, 16'h8000, 16'h0); set_b(1'b0, 16'h0022, 16'h0); end
         if (c == 3 || c == 4) set_b(1'b0, 16'h0022, 16'h0);
         #1;
         case (c)
            0: eg = 2'b01;
            1: eg = 2'b01;
            2: eg = 2'b10;
            3: eg = 2'b00;
            4: eg = 2'b01;
            default: eg = 2'b00;
         endcase
         vectors++; if ({a_gnt, b_gnt} !== eg) begin miscompares++; $display("FAIL workcons_gnt c%0d got=%b%b exp=%b", c, a_gnt, b_gnt, eg); end
         if (c == 5) begin
            vectors++; if (a_rvalid !== 1'b1 || a_rdata !== exp_data(16'h8000)) begin miscompares++; $display("FAIL workcons_adata got=%b/%h exp=1/%h", a_rvalid, a_rdata, exp_data(16'h8000)); end
         end
      end
      shadow[16'h0021] = 16'hBEEF;
   endtask

   typedef struct { int due; logic port; logic [15:0] data; } ret_t;

   task automatic test_random();
      ret_t        q[$];
      logic        m_last, m_rdp, p_wen;
      logic [1:0]  m_rdb;
      logic [15:0] p_addr, p_data;
      logic        ar, aw, br, bw, ea, eb, ga, gb, era, erb, we;
      logic [15:0] aa, ad, ba, bd, ed, addr, data;
      localparam int N = 400;
      apply_reset();
      m_last = 1'b1; m_rdp = 1'b0; m_rdb = 2'b00; p_wen = 1'b0; p_addr = 16'h0; p_data = 16'h0;
      ar = 1'b0; br = 1'b0; aw = 1'b0; bw = 1'b0; aa = 16'h0; ba = 16'h0; ad = 16'h0; bd = 16'h0;
      for (int c = 0; c < N; c++) begin
         @(negedge clk);
         if (!ar && c < N - 10 && $urandom_range(0, 99) < 60) begin
            ar = 1'b1; aw = ($urandom_range(0, 2) == 0);
            aa = {2'($urandom_range(0, 3)), 11'd0, 3'($urandom_range(0, 7))}; ad = 16'($urandom);
         end
         if (!br && c < N - 10 && $urandom_range(0, 99) < 60) begin
            br = 1'b1; bw = ($urandom_range(0, 2) == 0);
            ba = {2'($urandom_range(0, 3)), 11'd0, 3'($urandom_range(0, 7))}; bd = 16'($urandom);
         end
         a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
         b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
         #1;
         ea = ar && (!m_rdp || aa[15:14] == m_rdb);
         eb = br && (!m_rdp || ba[15:14] == m_rdb);
         ga = ea && (!eb || m_last);
         gb = eb && (!ea || !m_last);
         vectors++; if (a_gnt !== ga || b_gnt !== gb) begin miscompares++; $display("FAIL rand_gnt c%0d got=%b%b exp=%b%b", c, a_gnt, b_gnt, ga, gb); end
         vectors++; if (mem_wen !== p_wen) begin miscompares++; $display("FAIL rand_wen c%0d got=%b exp=%b", c, mem_wen, p_wen); end
         if (p_wen) begin
            vectors++; if (mem_addr !== p_addr || mem_wdata !== p_data) begin miscompares++; $display("FAIL rand_issue c%0d got=%h/%h exp=%h/%h", c, mem_addr, mem_wdata, p_addr, p_data); end
         end
         era = 1'b0; erb = 1'b0; ed = 16'h0;
         if (q.size() > 0 && q[0].due == c) begin
            era = !q[0].port; erb = q[0].port; ed = q[0].data;
            void'(q.pop_front());
         end
         vectors++; if (a_rvalid !== era || b_rvalid !== erb) begin miscompares++; $display("FAIL rand_rvalid c%0d got=%b%b exp=%b%b", c, a_rvalid, b_rvalid, era, erb); end
         if (era) begin
            vectors++; if (a_rdata !== ed) begin miscompares++; $display("FAIL rand_adata c%0d got=%h exp=%h", c, a_rdata, ed); end
         end
         if (erb) begin
            vectors++; if (b_rdata !== ed) begin miscompares++; $display("FAIL rand_bdata c%0d got=%h exp=%h", c, b_rdata, ed); end
         end
         p_wen = 1'b0; m_rdp = 1'b0;
         if (ga || gb) begin
            we   = gb ? bw : aw;
            addr = gb ? ba : aa;
            data = gb ? bd : ad;
            m_last = gb;
            p_wen = we; p_addr = addr; p_data = data;
            if (we) shadow[int'(addr)] = data;
            else begin
               q.push_back('{c + 3, gb, exp_data(addr)});
               m_rdp = 1'b1; m_rdb = addr[15:14];
            end
            if (ga) ar = 1'b0;
            if (gb) br = 1'b0;
         end
      end
      vectors++; if (q.size() != 0 || ar || br) begin miscompares++; $display("FAIL rand_drain left=%0d reqs=%b%b exp empty", q.size(), ar, br); end
      @(negedge clk); idle();
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset_mid_read();
      apply_reset();
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         idle();
         if (c == 0) set_a(1'b0, 16'h0031, 16'h0);
         if (c == 1) set_a(1'b0, 16'h0030, 16'h0);
         if (c == 4 || c == 5) begin set_a(1'b0, 16'h0040, 16'h0); set_b(1'b0, 16'h0041, 16'h0); end
         if (c == 6) resetn = 1'b1;
         if (c == 7) begin set_a(1'b0, 16'h0040, 16'h0); set_b(1'b0, 16'h0041, 16'h0); end
         #1;
         if (c < 2) begin
            vectors++; if (a_gnt !== 1'b1) begin miscompares++; $display("FAIL midrst_gnt c%0d got=%b exp=1", c, a_gnt); end
         end
         if (c == 3) begin
            vectors++; if (a_rvalid !== 1'b1 || a_rdata !== exp_data(16'h0031)) begin miscompares++; $display("FAIL midrst_first got=%b/%h exp=1/%h", a_rvalid, a_rdata, exp_data(16'h0031)); end
            #2 resetn = 1'b0;
         end
         if (c == 4) begin
            vectors++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin miscompares++; $display("FAIL midrst_gnt_low got=%b%b exp=00", a_gnt, b_gnt); end
            vectors++; if (mem_wen !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin miscompares++; $display("FAIL midrst_mem got=%b/%h/%h exp=0/0000/0000", mem_wen, mem_addr, mem_wdata); end
            vectors++; if (a_rdata !== 16'h0 || b_rdata !== 16'h0) begin miscompares++; $display("FAIL midrst_rdata got=%h/%h exp=0000/0000", a_rdata, b_rdata); end
         end
         if (c >= 4) begin
            vectors++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin miscompares++; $display("FAIL midrst_rvalid c%0d got=%b%b exp=00", c, a_rvalid, b_rvalid); end
         end
         if (c == 7) begin
            vectors++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin miscompares++; $display("FAIL midrst_tie got=%b%b exp=10", a_gnt, b_gnt); end
         end
      end
      @(negedge clk); idle();
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = init_val(16'(i));
      for (int i = 0; i < 4; i++) bank_q[i] = 16'h0;
      test_reset();
      test_write_read();
      test_conflict();
      test_bank_hazard(16'h4010, 1'b1);
      test_bank_hazard(16'h0011, 1'b0);
      test_work_conserving();
      test_random();
      test_reset_mid_read();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
